// File: rtl/multicycle_control.sv
// Multicycle FSM controller for a small LEGv8-style datapath.
// Strobes are decoded from the current state and the instruction class latched in DECODE.
module multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_imm,
    output logic        reg2_loc,
    output logic [1:0]  alu_op,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_WB_R     = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_WB_MEM   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_HALT     = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE    = 3'd0,
        CL_RTYPE   = 3'd1,
        CL_LDUR    = 3'd2,
        CL_STUR    = 3'd3,
        CL_CBZ     = 3'd4,
        CL_B       = 3'd5,
        CL_ILLEGAL = 3'd6
    } class_t;

    localparam logic [10:0] OP_LDUR = 11'd1986;
    localparam logic [10:0] OP_STUR = 11'd1984;
    localparam logic [10:0] OP_ADD  = 11'd1112;
    localparam logic [10:0] OP_SUB  = 11'd1624;
    localparam logic [10:0] OP_AND  = 11'd1104;
    localparam logic [10:0] OP_ORR  = 11'd1360;
    localparam logic [7:0]  OP_CBZ  = 8'd180;
    localparam logic [5:0]  OP_B    = 6'd5;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_CBZ    = 2'd1;
    localparam logic [1:0] PC_B      = 2'd2;
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_PASSB = 2'd1;
    localparam logic [1:0] ALU_RTYPE = 2'd2;

    state_t      state_q;
    class_t      class_q;
    class_t      class_d;
    logic        illegal_q;
    logic [31:0] instret_q;
    logic        retire;

    // Operand fields are consumed by the datapath, not by the controller.
    logic unused_operand_bits;
    assign unused_operand_bits = ^instruction[20:0];

    // Opcode decode; CBZ and B are tested before the 11-bit opcodes.
    always_comb begin
        class_d = CL_ILLEGAL;
        if (instruction[31:24] == OP_CBZ) begin
            class_d = CL_CBZ;
        end else if (instruction[31:26] == OP_B) begin
            class_d = CL_B;
        end else begin
            case (instruction[31:21])
                OP_ADD, OP_SUB, OP_AND, OP_ORR: class_d = CL_RTYPE;
                OP_LDUR:                        class_d = CL_LDUR;
                OP_STUR:                        class_d = CL_STUR;
                default:                        class_d = CL_ILLEGAL;
            endcase
        end
    end

    always_comb begin
        retire = 1'b0;
        case (state_q)
            ST_WB_R, ST_WB_MEM, ST_BRANCH: retire = 1'b1;
            ST_MEM_WR:                     retire = mem_ready;
            default:                       retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            class_q   <= CL_NONE;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    class_q <= class_d;
                    case (class_d)
                        CL_RTYPE:        state_q <= ST_EXEC_R;
                        CL_LDUR, CL_STUR: state_q <= ST_MEM_ADDR;
                        CL_CBZ, CL_B:    state_q <= ST_BRANCH;
                        default: begin
                            state_q   <= ST_HALT;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                ST_EXEC_R:   state_q <= ST_WB_R;
                ST_WB_R:     state_q <= ST_FETCH;
                ST_MEM_ADDR: state_q <= (class_q == CL_LDUR) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD: begin
                    if (mem_ready) state_q <= ST_WB_MEM;
                end
                ST_WB_MEM:   state_q <= ST_FETCH;
                ST_MEM_WR: begin
                    if (mem_ready) state_q <= ST_FETCH;
                end
                ST_BRANCH:   state_q <= ST_FETCH;
                ST_HALT:     state_q <= ST_HALT;
                default:     state_q <= ST_FETCH;
            endcase
        end
    end

    // Strobes are forced low while reset is held so an aborted access never completes.
    always_comb begin
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_PLUS4;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_imm = 1'b0;
        reg2_loc    = 1'b0;
        alu_op      = ALU_ADD;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_EXEC_R: alu_op = ALU_RTYPE;
                ST_WB_R:   reg_write = 1'b1;
                ST_MEM_ADDR: begin
                    alu_op      = ALU_ADD;
                    alu_src_imm = 1'b1;
                end
                ST_MEM_RD: mem_read = 1'b1;
                ST_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_write = 1'b1;
                    reg2_loc  = 1'b1;
                end
                ST_BRANCH: begin
                    if (class_q == CL_CBZ) begin
                        alu_op   = ALU_PASSB;
                        reg2_loc = 1'b1;
                        pc_src   = PC_CBZ;
                        pc_write = zero;
                    end else if (class_q == CL_B) begin
                        pc_src   = PC_B;
                        pc_write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

    a_mem_exclusive : assert property (@(posedge clk) !(mem_read && mem_write));
    a_halt_quiet    : assert property (@(posedge clk)
                          (state_q == ST_HALT) |-> !(reg_write || pc_write || mem_write || mem_read));

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into its expected
// per-cycle strobe trace from the controller's behavioural rules and compared cycle by cycle.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        zero;
    logic        mem_ready;
    logic        ir_write, pc_write, mem_read, mem_write, reg_write;
    logic        mem_to_reg, alu_src_imm, reg2_loc, illegal;
    logic [1:0]  pc_src, alu_op;
    logic [3:0]  state;
    logic [31:0] instret;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_instret;

    localparam int K_R = 0, K_LDUR = 1, K_STUR = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_WB_R = 4'd3,
                           S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5, S_WB_MEM = 4'd6,
                           S_MEM_WR = 4'd7, S_BRANCH = 4'd8, S_HALT = 4'd9;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .alu_src_imm (alu_src_imm),
        .reg2_loc    (reg2_loc),
        .alu_op      (alu_op),
        .state       (state),
        .illegal     (illegal),
        .instret     (instret)
    );

    logic [11:0] obs;
    assign obs = {mem_read, mem_write, reg_write, pc_write, ir_write, pc_src,
                  mem_to_reg, alu_src_imm, reg2_loc, alu_op};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [11:0] pk(input logic mr, input logic mw, input logic rw,
                                       input logic pw, input logic iw, input logic [1:0] ps,
                                       input logic mtr, input logic asi, input logic r2l,
                                       input logic [1:0] ao);
        return {mr, mw, rw, pw, iw, ps, mtr, asi, r2l, ao};
    endfunction

    function automatic logic coin();
        return 1'($urandom);
    endfunction

    function automatic int classify(input logic [31:0] w);
        logic [10:0] op;
        op = w[31:21];
        if (w[31:24] == 8'd180) return K_CBZ;
        if (w[31:26] == 6'd5) return K_B;
        if (op == 11'd1112 || op == 11'd1624 || op == 11'd1104 || op == 11'd1360) return K_R;
        if (op == 11'd1986) return K_LDUR;
        if (op == 11'd1984) return K_STUR;
        return K_ILL;
    endfunction

    function automatic logic [31:0] make_word(input int kind);
        logic [31:0] r;
        logic [10:0] rop;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       rop = 11'd1112;
            1:       rop = 11'd1624;
            2:       rop = 11'd1104;
            default: rop = 11'd1360;
        endcase
        case (kind)
            K_R:    return {rop, r[20:0]};
            K_LDUR: return {11'd1986, r[20:0]};
            K_STUR: return {11'd1984, r[20:0]};
            K_CBZ:  return {8'd180, r[23:0]};
            K_B:    return {6'd5, r[25:0]};
            default: begin
                while (classify(r) != K_ILL) r = $urandom;
                return r;
            end
        endcase
    endfunction

    // Reset for one edge; strobes must be low while rst is high, state/flags cleared after.
    task automatic do_reset(input logic rdy);
        rst         = 1'b1;
        mem_ready   = rdy;
        instruction = $urandom;
        zero        = coin();
        #4;
        check("rst_strobes", 32'(obs), 32'd0);
        @(posedge clk); #1;
        rst         = 1'b0;
        exp_instret = 32'd0;
        #1;
        check("rst_state", 32'(state), 32'(S_FETCH));
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_instret", instret, 32'd0);
    endtask

    // Runs one instruction from FETCH; optionally aborts it with reset in its final memory cycle.
    task automatic run_instr(input logic [31:0] word, input int fw, input int mw,
                             input logic z, input logic abort);
        logic [11:0] ev[$];
        logic [3:0]  es[$];
        logic        rq[$];
        int          kind;
        int          dec_i;
        int          ab_i;
        int          n;
        kind = classify(word);
        for (int i = 0; i < fw; i++) begin
            ev.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
            es.push_back(S_FETCH); rq.push_back(1'b0);
        end
        ev.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
        es.push_back(S_FETCH); rq.push_back(1'b1);
        dec_i = ev.size();
        ev.push_back(12'd0); es.push_back(S_DECODE); rq.push_back(coin());
        case (kind)
            K_R: begin
                ev.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd2));
                es.push_back(S_EXEC_R); rq.push_back(coin());
                ev.push_back(pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
                es.push_back(S_WB_R); rq.push_back(coin());
            end
            K_LDUR, K_STUR: begin
                ev.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0));
                es.push_back(S_MEM_ADDR); rq.push_back(coin());
                for (int i = 0; i <= mw; i++) begin
                    if (kind == K_LDUR) begin
                        ev.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
                        es.push_back(S_MEM_RD);
                    end else begin
                        ev.push_back(pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0));
                        es.push_back(S_MEM_WR);
                    end
                    rq.push_back(i == mw);
                end
                if (kind == K_LDUR) begin
                    ev.push_back(pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
                    es.push_back(S_WB_MEM); rq.push_back(coin());
                end
            end
            K_CBZ: begin
                ev.push_back(pk(1'b0, 1'b0, 1'b0, z, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 2'd1));
                es.push_back(S_BRANCH); rq.push_back(coin());
            end
            K_B: begin
                ev.push_back(pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0));
                es.push_back(S_BRANCH); rq.push_back(coin());
            end
            default: begin
                for (int i = 0; i < 20; i++) begin
                    ev.push_back(12'd0); es.push_back(S_HALT); rq.push_back(coin());
                end
            end
        endcase
        ab_i = -1;
        if (abort) begin
            for (int i = 0; i < ev.size(); i++)
                if (es[i] == S_MEM_RD || es[i] == S_MEM_WR) ab_i = i;
        end
        n = (ab_i >= 0) ? ab_i : ev.size();
        for (int i = 0; i < n; i++) begin
            instruction = (i == dec_i) ? word : $urandom;
            mem_ready   = rq[i];
            zero        = (es[i] == S_BRANCH) ? z : coin();
            #4;
            check("strobes", 32'(obs), 32'(ev[i]));
            check("state", 32'(state), 32'(es[i]));
            check("illegal", 32'(illegal), 32'(es[i] == S_HALT));
            check("instret", instret, exp_instret);
            @(posedge clk); #1;
        end
        if (ab_i >= 0) begin
            check("abort_state", 32'(state), 32'(es[ab_i]));
            do_reset(1'b1);
        end else if (kind != K_ILL) begin
            exp_instret = exp_instret + 32'd1;
        end
        $display("instr %08h kind=%0d cycles=%0d abort=%0d instret=%08h",
                 word, kind, n, (ab_i >= 0), instret);
    endtask

    initial begin
        int kind;
        rst         = 1'b1;
        instruction = 32'd0;
        zero        = 1'b0;
        mem_ready   = 1'b0;
        exp_instret = 32'd0;
        @(posedge clk); #1;
        do_reset(1'b0);

        run_instr(32'h8B02_0020, 0, 0, 1'b0, 1'b0);
        run_instr({11'd1986, 21'h0_0421}, 0, 3, 1'b0, 1'b0);
        run_instr(32'hB400_0040, 0, 0, 1'b1, 1'b0);
        run_instr(32'hB400_0040, 0, 0, 1'b0, 1'b0);
        run_instr(32'h1400_0003, 0, 0, 1'b0, 1'b0);
        run_instr({11'd1984, 21'h1_2345}, 1, 2, 1'b0, 1'b0);
        run_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0);
        do_reset(coin());

        force dut.instret_q = 32'hFFFF_FFFE;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFE;
        run_instr(32'h1400_0003, 0, 0, 1'b0, 1'b0);
        run_instr(32'hB400_0040, 0, 0, 1'b0, 1'b0);
        check("wrap", instret, 32'd0);

        run_instr({11'd1984, 21'h0_0007}, 0, 2, 1'b0, 1'b1);
        run_instr({11'd1986, 21'h0_0007}, 1, 1, 1'b0, 1'b1);

        for (int t = 0; t < 80; t++) begin
            kind = (($urandom_range(0, 11)) == 0) ? K_ILL : int'($urandom_range(0, 4));
            run_instr(make_word(kind), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                      coin(), ($urandom_range(0, 7) == 0));
            if (kind == K_ILL) do_reset(coin());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
